// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters advanced on pix_ce, with blanking,
// sync levels and one-clk edge strobes all decoded from the next count values.
module video_timing_gen #(
  parameter int H_TOTAL  = 384,
  parameter int H_ACTIVE = 256,
  parameter int HS_START = 280,
  parameter int HS_END   = 312,
  parameter int V_TOTAL  = 272,
  parameter int VA_START = 16,
  parameter int VA_END   = 256,
  parameter int VS_START = 260,
  parameter int VS_END   = 264
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_ce,
  output logic [8:0] hcount,
  output logic [8:0] vcount,
  output logic       hblank,
  output logic       vblank,
  output logic       hsync,
  output logic       vsync,
  output logic       hblank_rise,
  output logic       vblank_rise,
  output logic       frame_start
);

  localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
  localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);

  // Compares are done at 10 bits so that boundaries equal to 512 still fit.
  localparam logic [9:0] H_ACT = 10'(H_ACTIVE);
  localparam logic [9:0] HS_S  = 10'(HS_START);
  localparam logic [9:0] HS_E  = 10'(HS_END);
  localparam logic [9:0] VA_S  = 10'(VA_START);
  localparam logic [9:0] VA_E  = 10'(VA_END);
  localparam logic [9:0] VS_S  = 10'(VS_START);
  localparam logic [9:0] VS_E  = 10'(VS_END);

  logic       line_wrap;
  logic [8:0] h_next;
  logic [8:0] v_next;
  logic [9:0] h_ext;
  logic [9:0] v_ext;
  logic       hblank_next;
  logic       vblank_next;
  logic       hsync_next;
  logic       vsync_next;

  // Levels are decoded from the count values the registers are about to take, so the
  // registered levels always line up with the registered counts on the same cycle.
  always_comb begin
    line_wrap = (hcount == H_LAST);
    h_next    = line_wrap ? 9'd0 : hcount + 9'd1;
    v_next    = vcount;
    if (line_wrap) begin
      v_next = (vcount == V_LAST) ? 9'd0 : vcount + 9'd1;
    end
    h_ext       = {1'b0, h_next};
    v_ext       = {1'b0, v_next};
    hblank_next = (h_ext >= H_ACT);
    hsync_next  = (h_ext >= HS_S) && (h_ext < HS_E);
    vblank_next = !((v_ext >= VA_S) && (v_ext < VA_E));
    vsync_next  = (v_ext >= VS_S) && (v_ext < VS_E);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount      <= 9'd0;
      vcount      <= 9'd0;
      hblank      <= 1'b0;
      vblank      <= 1'b1;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      hblank_rise <= 1'b0;
      vblank_rise <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hblank_rise <= 1'b0;
      vblank_rise <= 1'b0;
      frame_start <= 1'b0;
      if (pix_ce) begin
        hcount      <= h_next;
        vcount      <= v_next;
        hblank      <= hblank_next;
        vblank      <= vblank_next;
        hsync       <= hsync_next;
        vsync       <= vsync_next;
        hblank_rise <= hblank_next & ~hblank;
        vblank_rise <= vblank_next & ~vblank;
        frame_start <= (h_next == 9'd0) && (v_next == 9'd0);
      end
    end
  end

endmodule
